// File: rtl/imem_squash_unit_pkg.sv
// imem_squash_unit_pkg: message-width and counter-width helpers for the imem squash unit
package imem_squash_unit_pkg;

    function automatic int req_nbits(int opaque_nbits, int addr_nbits, int data_nbits);
        return 3 + opaque_nbits + addr_nbits + 2 + data_nbits;
    endfunction

    function automatic int resp_nbits(int opaque_nbits, int data_nbits);
        return 3 + opaque_nbits + 2 + 2 + data_nbits;
    endfunction

    function automatic int cnt_nbits(int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/imem_squash_counter.sv
// imem_squash_counter: up/down counter with a synchronous load that overrides counting
module imem_squash_counter #(
    parameter int p_nbits = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [p_nbits-1:0] load_val,
    input  logic               inc,
    input  logic               dec,
    output logic [p_nbits-1:0] count
);

    always_ff @(posedge clk)
        if (reset) count <= '0;
        else count <= load ? load_val : count + p_nbits'(inc) - p_nbits'(dec);

endmodule

// File: rtl/imem_squash_unit.sv
// imem_squash_unit: credit-limited imem request/response filter that silently consumes
// the responses of every fetch outstanding at a squash
module imem_squash_unit
    import imem_squash_unit_pkg::*;
#(
    parameter int p_req_nbits = req_nbits(8, 32, 32),
    parameter int p_resp_nbits = resp_nbits(8, 32),
    parameter int p_max_inflight = 4,
    localparam int p_cnt_nbits = cnt_nbits(p_max_inflight)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    squash,
    input  logic [p_req_nbits-1:0]  req_in_msg,
    input  logic                    req_in_val,
    output logic                    req_in_rdy,
    output logic [p_req_nbits-1:0]  req_out_msg,
    output logic                    req_out_val,
    input  logic                    req_out_rdy,
    input  logic [p_resp_nbits-1:0] resp_in_msg,
    input  logic                    resp_in_val,
    output logic                    resp_in_rdy,
    output logic [p_resp_nbits-1:0] resp_out_msg,
    output logic                    resp_out_val,
    input  logic                    resp_out_rdy,
    output logic [p_cnt_nbits-1:0]  inflight,
    output logic [p_cnt_nbits-1:0]  drop_pending
);

    logic                   credit;
    logic                   dropping;
    logic                   req_fire;
    logic                   resp_fire;
    logic                   drop_fire;
    logic [p_cnt_nbits-1:0] drop_load;

    always_comb begin
        credit = inflight < p_cnt_nbits'(p_max_inflight);
        dropping = squash | (drop_pending != '0);
        req_out_msg = req_in_msg;
        req_out_val = req_in_val & credit;
        req_in_rdy = req_out_rdy & credit;
        req_fire = req_out_val & req_out_rdy;
        resp_out_msg = resp_in_msg;
        resp_out_val = dropping ? 1'b0 : resp_in_val;
        resp_in_rdy = dropping ? 1'b1 : resp_out_rdy;
        resp_fire = resp_in_val & resp_in_rdy;
        drop_fire = resp_fire & dropping;
        // the redirect fetch issued alongside a squash is not stale; a response retiring now is
        drop_load = inflight - p_cnt_nbits'(resp_fire);
    end

    imem_squash_counter #(.p_nbits(p_cnt_nbits)) inflight_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .inc      (req_fire),
        .dec      (resp_fire),
        .count    (inflight)
    );

    imem_squash_counter #(.p_nbits(p_cnt_nbits)) drop_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (squash),
        .load_val (drop_load),
        .inc      (1'b0),
        .dec      (drop_fire),
        .count    (drop_pending)
    );

    always_ff @(posedge clk)
        if (!reset) begin
            assert (!(resp_in_val && inflight == '0))
                else $error("imem response with no outstanding fetch");
            assert (drop_pending <= inflight && inflight <= p_cnt_nbits'(p_max_inflight))
                else $error("counter invariant violated: inflight=%0d drop_pending=%0d", inflight, drop_pending);
        end

endmodule
